sim_test_ctrl: RTL

Simulation-only test-completion controller for the Verilator top. It consumes the snooped write stream produced by the sim SRAM interface (valid/address/data/mask) plus the GPIO pin vector. It decodes SW test status writes and the legacy GPIO completion word, runs a drain countdown, and asserts a finish request. It also provides a progress watchdog that fails hung tests.

---
 rtl/sim_test_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sim_test_ctrl.sv
// Simulation test-completion controller: decodes SW status writes and the legacy
// GPIO done word, drains, then pulses a single-cycle finish request.
module sim_test_ctrl #(
  parameter logic [31:0] StatusAddr     = 32'h0010_0000,
  parameter logic [15:0] PassCode       = 16'h900D,
  parameter logic [15:0] FailCode       = 16'hBAAD,
  parameter logic [31:0] LegacyGpioDone = 32'hDEAD_BEEF,
  parameter int unsigned DrainCycles    = 7,
  parameter int unsigned TimeoutCycles  = 1_000_000
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        wr_valid_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [3:0]  wr_mask_i,
  input  logic [31:0] gpio_pins_i,
  output logic [15:0] status_o,
  output logic [15:0] status_wr_cnt_o,
  output logic        test_done_o,
  output logic        test_passed_o,
  output logic        test_failed_o,
  output logic        timeout_o,
  output logic        finish_req_o
);

  localparam int unsigned DRAIN_W  = 8;
  localparam int unsigned IDLE_W   = 32;
  localparam int unsigned STATUS_W = 16;
  localparam int unsigned CNT_W    = 16;

  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DrainCycles - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TimeoutCycles - 1);
  localparam logic               WDOG_EN    = (TimeoutCycles != 0);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    FINISH = 2'd2,
    HALT   = 2'd3
  } state_e;

  state_e               state, state_nxt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [IDLE_W-1:0]    idle_cnt;

  logic status_hit_c;
  logic pass_hit_c;
  logic fail_hit_c;
  logic gpio_done_c;
  logic wdog_expire_c;
  logic set_pass_c;
  logic set_fail_c;
  logic set_timeout_c;
  logic drain_load_c;
  logic unused_bits_c;

  // Only the low half-word of the status register matters.
  assign unused_bits_c = ^{wr_data_i[31:16], wr_mask_i[3:2]};

  // Input decode.
  assign status_hit_c  = wr_valid_i && (wr_addr_i == StatusAddr) && (wr_mask_i[1:0] == 2'b11);
  assign pass_hit_c    = status_hit_c && (wr_data_i[15:0] == PassCode);
  assign fail_hit_c    = status_hit_c && (wr_data_i[15:0] == FailCode);
  assign gpio_done_c   = (gpio_pins_i == LegacyGpioDone);
  assign wdog_expire_c = WDOG_EN && !wr_valid_i && (idle_cnt == IDLE_LAST);

  // Next-state and verdict decision; status verdict beats GPIO beats watchdog.
  always_comb begin
    state_nxt     = state;
    set_pass_c    = 1'b0;
    set_fail_c    = 1'b0;
    set_timeout_c = 1'b0;
    drain_load_c  = 1'b0;
    case (state)
      RUN: begin
        if (pass_hit_c) begin
          set_pass_c   = 1'b1;
          drain_load_c = 1'b1;
          state_nxt    = DRAIN;
        end else if (fail_hit_c) begin
          set_fail_c   = 1'b1;
          drain_load_c = 1'b1;
          state_nxt    = DRAIN;
        end else if (gpio_done_c) begin
          set_pass_c   = 1'b1;
          drain_load_c = 1'b1;
          state_nxt    = DRAIN;
        end else if (wdog_expire_c) begin
          set_fail_c    = 1'b1;
          set_timeout_c = 1'b1;
          drain_load_c  = 1'b1;
          state_nxt     = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          state_nxt = FINISH;
        end
      end
      FINISH:  state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Drain countdown: DrainCycles cycles spent in DRAIN.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      drain_cnt <= '0;
    end else if (drain_load_c) begin
      drain_cnt <= DRAIN_LOAD;
    end else if ((state == DRAIN) && (drain_cnt != '0)) begin
      drain_cnt <= drain_cnt - DRAIN_W'(1);
    end
  end

  // Progress watchdog counts idle cycles only while the test is running.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      idle_cnt <= '0;
    end else if (state == RUN) begin
      if (wr_valid_i) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end

  // Status mirror and saturating write count, live in every state.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      status_o        <= '0;
      status_wr_cnt_o <= '0;
    end else if (status_hit_c) begin
      status_o <= wr_data_i[STATUS_W-1:0];
      if (status_wr_cnt_o != '1) begin
        status_wr_cnt_o <= status_wr_cnt_o + CNT_W'(1);
      end
    end
  end

  // Sticky verdict flags; decisions only happen in RUN so the verdict freezes.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      test_done_o   <= 1'b0;
      test_passed_o <= 1'b0;
      test_failed_o <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      test_done_o   <= test_done_o | set_pass_c | set_fail_c;
      test_passed_o <= test_passed_o | set_pass_c;
      test_failed_o <= test_failed_o | set_fail_c;
      timeout_o     <= timeout_o | set_timeout_c;
    end
  end

  // Finish request is high exactly while the FSM sits in FINISH.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      finish_req_o <= 1'b0;
    end else begin
      finish_req_o <= (state_nxt == FINISH);
    end
  end

endmodule
